// File: rtl/serial_byte_feeder_pkg.sv
// Shared types and constants for the serial byte feeder and the downstream
// 11011 sequence detector it drives.
package serial_byte_feeder_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } feeder_state_e;

    localparam logic [4:0]  SEQ_PATTERN = 5'b11011;
    localparam int unsigned SEQ_LEN     = 5;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_byte_feeder_if.sv
// Host-side byte handshake and detector-side serial stream of the feeder.
interface serial_byte_feeder_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              ser_bit;
    logic              ser_valid;
    logic              busy;
    logic              frame_done;

    modport master (
        output in_data, in_valid,
        input  in_ready, ser_bit, ser_valid, busy, frame_done
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, ser_bit, ser_valid, busy, frame_done
    );
endinterface

// File: rtl/serial_byte_feeder_bit_tick_gen.sv
// Bit-period timer: o_tick is a registered strobe on the first cycle of each
// bit period, o_last flags the final cycle of the current period.
module serial_byte_feeder_bit_tick_gen
    import serial_byte_feeder_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_stop,
    output logic o_tick,
    output logic o_last
);
    localparam int unsigned      CNT_W    = cnt_width(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_div_cnt;
    logic             r_run;
    logic             r_tick;

    // Divider counter; a start always begins a fresh period even while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= {CNT_W{1'b0}};
            r_run     <= 1'b0;
            r_tick    <= 1'b0;
        end else if (i_start) begin
            r_div_cnt <= {CNT_W{1'b0}};
            r_run     <= 1'b1;
            r_tick    <= 1'b1;
        end else if (i_stop) begin
            r_div_cnt <= {CNT_W{1'b0}};
            r_run     <= 1'b0;
            r_tick    <= 1'b0;
        end else if (r_run && (r_div_cnt == CNT_LAST)) begin
            r_div_cnt <= {CNT_W{1'b0}};
            r_tick    <= 1'b1;
        end else if (r_run) begin
            r_div_cnt <= r_div_cnt + CNT_W'(1);
            r_tick    <= 1'b0;
        end else begin
            r_tick    <= 1'b0;
        end
    end

    assign o_tick = r_tick;
    assign o_last = r_run && (r_div_cnt == CNT_LAST);

endmodule

// File: rtl/serial_byte_feeder.sv
// Serializes host-written bytes into a bit stream plus clock-enable strobe
// for the 11011 sequence detector, with zero-bubble back-to-back frames.
module serial_byte_feeder
    import serial_byte_feeder_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DIV       = 1,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_byte_feeder_if.slave  bus
);
    localparam int unsigned      BIT_W    = cnt_width(DATA_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    feeder_state_e     r_state;
    feeder_state_e     w_state_nxt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              r_ser_bit;
    logic              r_busy;
    logic              r_frame_done;
    logic              w_tick;
    logic              w_last;
    logic              w_frame_last;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_stop;
    logic              w_first_bit;
    logic              w_next_bit;

    serial_byte_feeder_bit_tick_gen #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_accept),
        .i_stop  (w_stop),
        .o_tick  (w_tick),
        .o_last  (w_last)
    );

    assign w_frame_last = (r_state == ST_SHIFT) && w_last && (r_bit_cnt == BIT_LAST);
    assign w_in_ready   = !rst && ((r_state == ST_IDLE) || w_frame_last);
    assign w_accept     = bus.in_valid && w_in_ready;

    // Bit ordering: the bit on the wire is always the shift register's exit end.
    always_comb begin
        w_shift_nxt = r_shift;
        w_first_bit = 1'b0;
        w_next_bit  = 1'b0;
        if (MSB_FIRST) begin
            w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
            w_first_bit = bus.in_data[DATA_W-1];
            w_next_bit  = r_shift[DATA_W-2];
        end else begin
            w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
            w_first_bit = bus.in_data[0];
            w_next_bit  = r_shift[1];
        end
    end

    // Next-state logic; leaving SHIFT only when the last bit ends with no new byte.
    always_comb begin
        w_state_nxt = r_state;
        w_stop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_frame_last && !w_accept) begin
                    w_state_nxt = ST_IDLE;
                    w_stop      = 1'b1;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift datapath and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift      <= {DATA_W{1'b0}};
            r_bit_cnt    <= {BIT_W{1'b0}};
            r_ser_bit    <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_last;
            if (w_accept) begin
                r_shift   <= bus.in_data;
                r_bit_cnt <= {BIT_W{1'b0}};
                r_ser_bit <= w_first_bit;
                r_busy    <= 1'b1;
            end else if (w_stop) begin
                r_shift   <= {DATA_W{1'b0}};
                r_bit_cnt <= {BIT_W{1'b0}};
                r_ser_bit <= 1'b0;
                r_busy    <= 1'b0;
            end else if ((r_state == ST_SHIFT) && w_last) begin
                r_shift   <= w_shift_nxt;
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                r_ser_bit <= w_next_bit;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.ser_bit    = r_ser_bit;
    assign bus.ser_valid  = w_tick;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

endmodule
